// File: rtl/typec_pkg.sv
// Shared Type-C receive definitions: PID bytes, packet class codes, header nibbles, CRC-8 step.
package typec_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'h01;

  localparam logic [7:0] PID_ACK     = 8'h2D;
  localparam logic [7:0] PID_NAK     = 8'hA5;
  localparam logic [7:0] PID_STALL   = 8'hE1;
  localparam logic [7:0] PID_DLINK   = 8'h3C;
  localparam logic [7:0] PID_DEV     = 8'h1E;
  localparam logic [7:0] PID_DATA0   = 8'h96;
  localparam logic [7:0] PID_DATA1   = 8'h5A;

  localparam logic [3:0] BAG_INIT    = 4'h0;
  localparam logic [3:0] BAG_ACK     = 4'h1;
  localparam logic [3:0] BAG_NAK     = 4'h2;
  localparam logic [3:0] BAG_STALL   = 4'h3;
  localparam logic [3:0] BAG_DIDX    = 4'h5;
  localparam logic [3:0] BAG_DPARAM  = 4'h6;
  localparam logic [3:0] BAG_DDIDX   = 4'h7;
  localparam logic [3:0] BAG_DLINK   = 4'h8;
  localparam logic [3:0] BAG_DATA0   = 4'hD;
  localparam logic [3:0] BAG_DATA1   = 4'hE;
  localparam logic [3:0] BAG_ERROR   = 4'hF;

  localparam logic [3:0] HEAD_DIDX   = 4'h9;
  localparam logic [3:0] HEAD_DDIDX  = 4'h1;
  localparam logic [3:0] HEAD_DPARAM = 4'h5;

  localparam logic [7:0] CRC_POLY    = 8'h07;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT, ST_RPID, ST_LEN0, ST_LEN1, ST_BODY, ST_CRC, ST_DONE, ST_ERROR
  } rx_state_e;

  // One byte of MSB-first CRC-8, evaluated bit-serially.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] din);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ din[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/typec_crc8.sv
// Running CRC-8 accumulator; clr restarts, en folds in one byte.
module typec_crc8
  import typec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= 8'h00;
    else if (clr) crc <= 8'h00;
    else if (en)  crc <= crc8_byte(crc, din);
  end

endmodule

// File: rtl/typec_rx_frame.sv
// Type-C receive framer: SYNC/PID/length/body/CRC parsing into a payload buffer.
// Optional inter-byte timeout enabled by defining TYPEC_RX_TIMEOUT_EN.
module typec_rx_frame
  import typec_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       fs,
  input  logic                       fd,
  output logic [3:0]                 btype,
  output logic [3:0]                 bdata,
  output logic [7:0]                 filter,
  output logic [15:0]                plen,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data
);

  localparam int unsigned AW = $clog2(MAX_LEN);

  rx_state_e   state;
  logic [7:0]  pid;
  logic [7:0]  len_hi;
  logic [15:0] cnt;
  logic [3:0]  head;
  logic [7:0]  crc_val;
  logic [15:0] len_c;
  logic        sync_c;
  logic        crc_en_c;
  logic        wr_en_c;
  logic        to_hit_c;
  logic [3:0]  pass_btype_c;
  logic [7:0]  mem [MAX_LEN];

  assign len_c    = {len_hi, rx_data};
  assign sync_c   = rx_valid && (state == ST_WAIT) && (rx_data == SYNC_BYTE);
  assign crc_en_c = rx_valid && (state inside {ST_LEN0, ST_LEN1, ST_BODY});
  assign wr_en_c  = rx_valid && (state == ST_BODY);

  typec_crc8 u_crc (
    .clk (clk),
    .rst (rst),
    .clr (sync_c),
    .en  (crc_en_c),
    .din (rx_data),
    .crc (crc_val)
  );

`ifdef TYPEC_RX_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        in_frame_c;

  assign in_frame_c = state inside {ST_LEN0, ST_LEN1, ST_BODY, ST_CRC};
  assign to_hit_c   = in_frame_c && !rx_valid && (to_cnt == 16'(TIMEOUT - 1));

  // Idle-cycle counter, restarted by every byte inside the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         to_cnt <= 16'd0;
    else if (!in_frame_c || rx_valid) to_cnt <= 16'd0;
    else                             to_cnt <= to_cnt + 16'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
  assign to_hit_c       = 1'b0;
`endif

  // Class reported when the CRC byte matches.
  always_comb begin
    pass_btype_c = BAG_ERROR;
    case (pid)
      PID_DATA0: pass_btype_c = BAG_DATA0;
      PID_DATA1: pass_btype_c = BAG_DATA1;
      PID_DEV: begin
        case (head)
          HEAD_DIDX:   pass_btype_c = BAG_DIDX;
          HEAD_DDIDX:  pass_btype_c = BAG_DDIDX;
          HEAD_DPARAM: pass_btype_c = BAG_DPARAM;
          default:     pass_btype_c = BAG_ERROR;
        endcase
      end
      default: pass_btype_c = BAG_ERROR;
    endcase
  end

  // Payload buffer: read-before-write, no reset on contents.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[cnt[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      btype  <= BAG_INIT;
      bdata  <= 4'h0;
      filter <= 8'h00;
      plen   <= 16'd0;
      fs     <= 1'b0;
      pid    <= 8'h00;
      len_hi <= 8'h00;
      cnt    <= 16'd0;
      head   <= 4'h0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_WAIT;
        ST_WAIT: begin
          if (sync_c) begin
            state  <= ST_RPID;
            btype  <= BAG_INIT;
            bdata  <= 4'h0;
            filter <= 8'h00;
            plen   <= 16'd0;
            head   <= 4'h0;
            cnt    <= 16'd0;
          end
        end
        ST_RPID: begin
          if (rx_valid) begin
            case (rx_data)
              PID_ACK:   begin btype <= BAG_ACK;   state <= ST_DONE; fs <= 1'b1; end
              PID_NAK:   begin btype <= BAG_NAK;   state <= ST_DONE; fs <= 1'b1; end
              PID_STALL: begin btype <= BAG_STALL; state <= ST_DONE; fs <= 1'b1; end
              PID_DLINK: begin btype <= BAG_DLINK; state <= ST_DONE; fs <= 1'b1; end
              PID_DEV, PID_DATA0, PID_DATA1: begin
                pid   <= rx_data;
                state <= ST_LEN0;
              end
              default:   begin btype <= BAG_ERROR; state <= ST_DONE; fs <= 1'b1; end
            endcase
          end
        end
        ST_LEN0: begin
          if (to_hit_c) begin
            btype <= BAG_ERROR;
            state <= ST_ERROR;
          end else if (rx_valid) begin
            len_hi <= rx_data;
            state  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (to_hit_c) begin
            btype <= BAG_ERROR;
            state <= ST_ERROR;
          end else if (rx_valid) begin
            plen <= len_c;
            cnt  <= 16'd0;
            if (len_c == 16'd0) begin
              state <= ST_CRC;
            end else if (len_c > 16'(MAX_LEN)) begin
              btype <= BAG_ERROR;
              state <= ST_ERROR;
            end else begin
              state <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (to_hit_c) begin
            btype <= BAG_ERROR;
            state <= ST_ERROR;
          end else if (rx_valid) begin
            if (cnt == 16'd0) begin
              bdata <= rx_data[3:0];
              head  <= rx_data[7:4];
            end
            if (cnt == 16'd1) filter <= rx_data;
            cnt <= cnt + 16'd1;
            if (cnt == plen - 16'd1) state <= ST_CRC;
          end
        end
        ST_CRC: begin
          if (to_hit_c) begin
            btype <= BAG_ERROR;
            state <= ST_ERROR;
          end else if (rx_valid) begin
            if (rx_data == crc_val) begin
              btype <= pass_btype_c;
              state <= ST_DONE;
              fs    <= 1'b1;
            end else begin
              btype <= BAG_ERROR;
              state <= ST_ERROR;
            end
          end
        end
        ST_ERROR: begin
          btype <= BAG_ERROR;
          state <= ST_DONE;
          fs    <= 1'b1;
        end
        ST_DONE: begin
          // Late bytes are dropped here; only the acknowledge moves on.
          if (fd) begin
            fs    <= 1'b0;
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_typec_rx_frame.sv
// Scoreboard bench for typec_rx_frame: frame-level reference model, decoupled monitor.
module tb_typec_rx_frame;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned AW      = $clog2(MAX_LEN);

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [3:0]  btype;
    logic [3:0]  bdata;
    logic [7:0]  filter;
    logic [15:0] plen;
    int          probe;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          fs;
  logic          fd;
  logic [3:0]    btype;
  logic [3:0]    bdata;
  logic [7:0]    filter;
  logic [15:0]   plen;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  exp_t       exp_q[$];
  logic [7:0] mem_model [MAX_LEN];
  bit         mem_known [MAX_LEN];
  int         n_cmp  = 0;
  int         n_bad  = 0;
  int         done_cnt = 0;
  int         issued = 0;

  typec_rx_frame #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .fs(fs), .fd(fd), .btype(btype), .bdata(bdata), .filter(filter),
    .plen(plen), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] crc_ref(input bq_t b);
    logic [7:0] c = 8'h00;
    foreach (b[i]) begin
      c ^= b[i];
      repeat (8) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Expected result of a complete frame, straight from the packet rules.
  function automatic exp_t model(input bq_t f);
    exp_t e;
    int   len;
    bq_t  cov;
    e = '{btype: 4'h0, bdata: 4'h0, filter: 8'h00, plen: 16'd0, probe: -1};
    case (f[1])
      8'h2D: e.btype = 4'h1;
      8'hA5: e.btype = 4'h2;
      8'hE1: e.btype = 4'h3;
      8'h3C: e.btype = 4'h8;
      8'h1E, 8'h96, 8'h5A: begin
        len    = {f[2], f[3]};
        e.plen = 16'(len);
        if (len > int'(MAX_LEN)) begin
          e.btype = 4'hF;
        end else begin
          for (int i = 2; i < 4 + len; i++) cov.push_back(f[i]);
          if (len > 0) e.bdata = f[4][3:0];
          if (len > 1) e.filter = f[5];
          if (f[4 + len] != crc_ref(cov))  e.btype = 4'hF;
          else if (f[1] == 8'h96)          e.btype = 4'hD;
          else if (f[1] == 8'h5A)          e.btype = 4'hE;
          else if (len == 0)               e.btype = 4'hF;
          else if (f[4][7:4] == 4'h9)      e.btype = 4'h5;
          else if (f[4][7:4] == 4'h1)      e.btype = 4'h7;
          else if (f[4][7:4] == 4'h5)      e.btype = 4'h6;
          else                             e.btype = 4'hF;
        end
      end
      default: e.btype = 4'hF;
    endcase
    return e;
  endfunction

  task automatic push_expected(input bq_t f, input int probe);
    exp_t e;
    int   len;
    e       = model(f);
    e.probe = probe;
    if (f[1] inside {8'h1E, 8'h96, 8'h5A}) begin
      len = {f[2], f[3]};
      if (len <= int'(MAX_LEN))
        for (int i = 0; i < len; i++) begin
          mem_model[i] = f[4 + i];
          mem_known[i] = 1'b1;
        end
    end
    exp_q.push_back(e);
    issued++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_range(input bq_t f, input int from, input int upto);
    for (int i = from; i < upto; i++) send_byte(f[i], $urandom_range(0, 2));
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt < issued && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("frame_done", 32'(done_cnt >= issued), 32'd1);
  endtask

  task automatic issue_frame(input bq_t f, input int probe);
    logic [7:0] junk;
    if ($urandom_range(0, 3) == 0) begin
      junk = 8'($urandom);
      if (junk == 8'h01) junk = 8'h02;
      send_byte(junk, 0);
    end
    push_expected(f, probe);
    send_range(f, 0, f.size());
    wait_done();
  endtask

  function automatic bq_t random_frame();
    bq_t        f;
    int         kind, len;
    logic [7:0] pid, crc;
    bq_t        cov;
    f.push_back(8'h01);
    kind = $urandom_range(0, 9);
    if (kind <= 1) begin
      case ($urandom_range(0, 4))
        0: pid = 8'h2D;
        1: pid = 8'hA5;
        2: pid = 8'hE1;
        3: pid = 8'h3C;
        default: begin
          pid = 8'($urandom);
          while (pid inside {8'h2D, 8'hA5, 8'hE1, 8'h3C, 8'h1E, 8'h96, 8'h5A}) pid = pid + 8'd1;
        end
      endcase
      f.push_back(pid);
    end else if (kind == 2) begin
      len = $urandom_range(MAX_LEN + 1, 65535);
      f.push_back(8'h5A);
      f.push_back(8'(len >> 8));
      f.push_back(8'(len));
    end else begin
      case ($urandom_range(0, 2))
        0: pid = 8'h1E;
        1: pid = 8'h96;
        default: pid = 8'h5A;
      endcase
      len = $urandom_range(0, MAX_LEN);
      f.push_back(pid);
      f.push_back(8'(len >> 8));
      f.push_back(8'(len));
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
      if (pid == 8'h1E && len > 0)
        case ($urandom_range(0, 3))
          0: f[4][7:4] = 4'h9;
          1: f[4][7:4] = 4'h1;
          2: f[4][7:4] = 4'h5;
          default: ;
        endcase
      for (int i = 2; i < f.size(); i++) cov.push_back(f[i]);
      crc = crc_ref(cov);
      if ($urandom_range(0, 3) == 0) crc = crc ^ 8'($urandom_range(1, 255));
      f.push_back(crc);
    end
    return f;
  endfunction

  // Monitor: every DONE episode is checked against the oldest expectation, then acknowledged.
  initial begin
    exp_t e;
    bit   probing;
    fd      = 1'b0;
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst && fs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fs", 32'(fs), 32'd0);
          e = '{btype: btype, bdata: bdata, filter: filter, plen: plen, probe: -1};
        end else begin
          e = exp_q.pop_front();
          chk("btype",  32'(btype),  32'(e.btype));
          chk("bdata",  32'(bdata),  32'(e.bdata));
          chk("filter", 32'(filter), 32'(e.filter));
          chk("plen",   32'(plen),   32'(e.plen));
        end
        if (e.probe < 0) e.probe = $urandom_range(0, MAX_LEN - 1);
        probing = mem_known[e.probe];
        rd_addr = AW'(e.probe);
        @(negedge clk);
        if (probing) chk("rd_data", 32'(rd_data), 32'(mem_model[e.probe]));
        chk("btype_stable", 32'(btype), 32'(e.btype));
        chk("fs_held", 32'(fs), 32'd1);
        fd = 1'b1;
        @(negedge clk);
        fd = 1'b0;
        chk("fs_clear_after_fd", 32'(fs), 32'd0);
        done_cnt++;
      end
    end
  end

  initial begin
    bq_t f, cov;
    exp_t e;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    foreach (mem_known[i]) mem_known[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fs",      32'(fs),      32'd0);
    chk("rst_btype",   32'(btype),   32'd0);
    chk("rst_bdata",   32'(bdata),   32'd0);
    chk("rst_filter",  32'(filter),  32'd0);
    chk("rst_plen",    32'(plen),    32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    f = '{8'h01, 8'h2D};
    issue_frame(f, -1);

    cov = '{8'h00, 8'h02, 8'h9A, 8'h3C};
    f   = '{8'h01, 8'h1E, 8'h00, 8'h02, 8'h9A, 8'h3C, 8'h00};
    f[6] = crc_ref(cov);
    issue_frame(f, 1);

    cov = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    f   = '{8'h01, 8'h96, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    f[8] = crc_ref(cov) ^ 8'hFF;
    issue_frame(f, 2);

    f = '{8'h01, 8'h5A, 8'h00, 8'(MAX_LEN + 1)};
    issue_frame(f, -1);

    // Stall after the first length byte.
`ifdef TYPEC_RX_TIMEOUT_EN
    e = '{btype: 4'hF, bdata: 4'h0, filter: 8'h00, plen: 16'd0, probe: -1};
    exp_q.push_back(e);
    issued++;
    send_byte(8'h01, 0);
    send_byte(8'h1E, 0);
    send_byte(8'h00, 0);
    repeat (9) @(negedge clk);
    wait_done();
`else
    cov = '{8'h00, 8'h02, 8'h5A, 8'h77};
    f   = '{8'h01, 8'h1E, 8'h00, 8'h02, 8'h5A, 8'h77, 8'h00};
    f[6] = crc_ref(cov);
    push_expected(f, 0);
    send_range(f, 0, 3);
    repeat (12) @(negedge clk);
    chk("no_timeout_fs", 32'(fs), 32'd0);
    send_range(f, 3, f.size());
    wait_done();
`endif

    // Reset in the middle of a body.
    f = '{8'h01, 8'h96, 8'h00, 8'h04, 8'h11, 8'h22};
    send_range(f, 0, f.size());
    rst = 1'b1;
    foreach (mem_known[i]) mem_known[i] = 1'b0;
    @(negedge clk);
    chk("midrst_fs",      32'(fs),      32'd0);
    chk("midrst_btype",   32'(btype),   32'd0);
    chk("midrst_bdata",   32'(bdata),   32'd0);
    chk("midrst_filter",  32'(filter),  32'd0);
    chk("midrst_plen",    32'(plen),    32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_fs", 32'(fs), 32'd0);
    f = '{8'h01, 8'h2D};
    issue_frame(f, -1);

    for (int n = 0; n < 40; n++) begin
      f = random_frame();
      issue_frame(f, -1);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/typec_rx_frame.md
TYPEC_RX_FRAME -- requirements
Module: typec_rx_frame

Interface
REQ-001 Parameter MAX_LEN, default 64, is the payload buffer depth in bytes (range 2..256).
REQ-002 Parameter TIMEOUT, default 255, is the inter-byte timeout in clk cycles (range 1..65535).
REQ-003 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-006 rx_valid  input  1  byte strobe, 1 cycle per byte.
REQ-007 fs  output  1  frame-status flag, high while in DONE.
REQ-008 fd  input  1  consumer acknowledge of fs.
REQ-009 btype  output  4  packet class (ACK=1, NAK=2, STALL=3, DIDX=5, DPARAM=6, DDIDX=7, DLINK=8, DATA0=D, DATA1=E, ERROR=F, INIT=0).
REQ-010 bdata  output  4  low nibble of body byte 0.
REQ-011 filter  output  8  body byte 1.
REQ-012 plen  output  16  received body length.
REQ-013 rd_addr  input  $clog2(MAX_LEN)  payload buffer read address.
REQ-014 rd_data  output  8  buffer byte at rd_addr, registered, 1-cycle latency.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RPID, LEN0, LEN1, BODY, CRC, DONE, ERROR; it SHALL advance only on rx_valid except IDLE->WAIT, ERROR->DONE, DONE->WAIT (each unconditional after 1 cycle, DONE on fd=1).
REQ-016 WAIT SHALL go to RPID on byte 0x01; other bytes are discarded.
REQ-017 RPID: 0x2D/0xA5/0xE1/0x3C SHALL set btype ACK/NAK/STALL/DLINK and go to DONE; 0x1E/0x96/0x5A SHALL go to LEN0; any other PID SHALL set btype ERROR and go to DONE.
REQ-018 LEN0 captures length[15:8], LEN1 length[7:0]; length 0 SHALL go directly to CRC; length > MAX_LEN SHALL go to ERROR.
REQ-019 BODY SHALL write each byte to buffer[cnt], cnt starting at 0, and leave for CRC after byte length-1.
REQ-020 CRC-8, polynomial 0x07, init 0x00, MSB-first, SHALL cover LEN0, LEN1 and all BODY bytes; CRC byte equal to computed value -> DONE, else -> ERROR.
REQ-021 For PID 0x1E, body byte 0 high nibble 0x9/0x1/0x5 SHALL set btype DIDX/DDIDX/DPARAM on CRC pass; any other nibble SHALL set btype ERROR; PID 0x96/0x5A SHALL set btype DATA0/DATA1 on CRC pass.
REQ-022 bdata SHALL load on body byte 0, filter on body byte 1; both hold otherwise and clear in WAIT on SYNC.
REQ-023 plen SHALL load at LEN1 and hold until next SYNC.
REQ-024 ERROR SHALL set btype ERROR for 1 cycle then enter DONE.
REQ-025 fs SHALL be high exactly in DONE; outputs SHALL be stable while fs=1; fd outside DONE SHALL be ignored.
REQ-026 rx_valid while in DONE SHALL be discarded (no queuing).
REQ-027 Buffer reads during a write to the same address SHALL return the old byte.

Reset
REQ-028 On rst: state IDLE, btype 0, bdata 0, filter 0, plen 0, fs 0, rd_data 0, CRC and counters 0; buffer contents undefined.
REQ-029 rst mid-frame SHALL abandon the frame without asserting fs.

Configuration
REQ-030 With TYPEC_RX_TIMEOUT_EN defined, a counter SHALL clear on each rx_valid in LEN0..CRC and, reaching TIMEOUT cycles without rx_valid, force ERROR; without it no timeout exists and the FSM waits indefinitely.

Structure
REQ-031 PID, BAG_* codes, HEAD_* nibbles and CRC polynomial SHALL live in shared package typec_pkg.
REQ-032 CRC-8 SHALL be sub-module typec_crc8 (clk, rst, clr, en, din[7:0], crc[7:0]).

Verification
REQ-033 01 2D -> fs=1, btype=1; fd pulse -> WAIT, fs=0 next cycle.
REQ-034 01 1E 00 02 9A 3C crc -> btype=5, bdata=A, filter=3C, plen=2.
REQ-035 01 96 00 04 11 22 33 44 bad-crc -> btype=F; rd_addr=2 -> rd_data=33 next cycle.
REQ-036 01 5A with length MAX_LEN+1 -> btype=F immediately after LEN1, fs=1.
REQ-037 TIMEOUT_EN, TIMEOUT=8: 01 1E 00 then 9 idle cycles -> btype=F, fs=1; without macro -> no fs.
REQ-038 rst asserted in BODY -> fs stays 0, all outputs 0, next 01 2D handled normally.
